// File: rtl/aloha_perm_pkg.sv
// Shared types and helpers for the Galois slot permutation datapath.
// Holds the run mode, the sequencer states and a width-selectable bit reversal.
package aloha_perm_pkg;

  typedef enum logic {
    GATHER  = 1'b0,
    SCATTER = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/galois_index_gen.sv
// Walks the rotation orbit p_j = GEN^j mod 2^(LOGN+1) and maps each orbit
// element to its slot index, mirror/conjugate flag and the running j count.
module galois_index_gen #(
  parameter int LOGN = 13,
  parameter int GEN  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_init,
  input  logic            i_advance,
  input  logic            i_conj_en,
  output logic [LOGN-2:0] o_idx,
  output logic            o_conj,
  output logic [LOGN-2:0] o_j
);
  import aloha_perm_pkg::*;

  localparam logic [LOGN:0] GEN_W = (LOGN+1)'(GEN);

  logic [LOGN:0]   r_p;
  logic [LOGN-2:0] r_j;
  logic [LOGN-1:0] w_half;
  logic [LOGN-1:0] w_e;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= (LOGN+1)'(1);
      r_j <= '0;
    end else if (i_init) begin
      r_p <= (LOGN+1)'(1);
      r_j <= '0;
    end else if (i_advance) begin
      r_p <= r_p * GEN_W;
      r_j <= r_j + 1'b1;
    end
  end

  // p is always odd, so (p-1)>>1 drops no information.
  assign w_half = LOGN'((r_p - 1'b1) >> 1);
  assign w_e    = LOGN'(bitrev(32'(w_half), LOGN));

  // Upper-half exponents fold onto their mirror N-1-e, whose low bits are ~e.
  assign o_idx  = w_e[LOGN-1] ? ~w_e[LOGN-2:0] : w_e[LOGN-2:0];
  assign o_conj = w_e[LOGN-1] & i_conj_en;
  assign o_j    = r_j;

endmodule

// File: rtl/galois_slot_permute.sv
// Moves S complex words between the two regions of the dual-bank FFT memory
// along the Galois orbit, with optional conjugation of mirrored slots.
module galois_slot_permute #(
  parameter int LOGN         = 13,
  parameter int FLP_WORDSIZE = 64,
  parameter int BRAM_RD_LAT  = 2,
  parameter int GEN          = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      conj_en,
  output logic                      busy,
  output logic                      done,
  output logic [LOGN-2:0]           fft_rd_addr,
  output logic [LOGN-2:0]           fft_wr_addr,
  output logic                      fft_bank0_wea,
  output logic                      fft_bank1_wea,
  input  logic [2*FLP_WORDSIZE-1:0] fft_bank0_rd_data,
  input  logic [2*FLP_WORDSIZE-1:0] fft_bank1_rd_data,
  output logic [2*FLP_WORDSIZE-1:0] fft_wr_data
);
  import aloha_perm_pkg::*;

  localparam int S   = 2**(LOGN-1);
  localparam int AW  = LOGN-1;
  localparam int DW  = 2*FLP_WORDSIZE;
  localparam int DCW = $clog2(BRAM_RD_LAT+1);

  typedef struct packed {
    logic          valid;
    logic          rd_bank;
    logic          wr_bank;
    logic          conj;
    logic [AW-1:0] wr_addr;
  } tag_t;

  state_e         r_state, w_next;
  mode_e          r_mode;
  logic           r_conj_en;
  logic [DCW-1:0] r_drain_cnt;
  logic [AW-1:0]  w_idx, w_j;
  logic           w_conj;
  logic           w_issue;
  logic [AW-1:0]  w_src_slot, w_dst_slot;
  logic           w_src_region, w_dst_region;
  tag_t           w_tag_in, w_tag_out;
  tag_t           r_tag [BRAM_RD_LAT];

  galois_index_gen #(
    .LOGN (LOGN),
    .GEN  (GEN)
  ) u_index_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_init    (r_state == IDLE),
    .i_advance (w_issue),
    .i_conj_en (r_conj_en),
    .o_idx     (w_idx),
    .o_conj    (w_conj),
    .o_j       (w_j)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = ISSUE;
      ISSUE:   if (w_j == AW'(S-1)) w_next = DRAIN;
      DRAIN:   if (r_drain_cnt == DCW'(BRAM_RD_LAT-1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= GATHER;
      r_conj_en   <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_mode    <= mode_e'(mode);
        r_conj_en <= conj_en;
      end
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 1'b1 : '0;
    end
  end

  assign w_issue = (r_state == ISSUE);

  always_comb begin
    w_src_slot   = w_idx;
    w_dst_slot   = w_j;
    w_src_region = 1'b0;
    w_dst_region = 1'b1;
    if (r_mode == SCATTER) begin
      w_src_slot   = w_j;
      w_dst_slot   = w_idx;
      w_src_region = 1'b1;
      w_dst_region = 1'b0;
    end
  end

  // Slot s lives in bank s[0] at row s[AW-1:1]; the region bit sits on top.
  assign fft_rd_addr = w_issue ? {w_src_region, w_src_slot[AW-1:1]} : '0;

  always_comb begin
    w_tag_in = '0;
    if (w_issue) begin
      w_tag_in.valid   = 1'b1;
      w_tag_in.rd_bank = w_src_slot[0];
      w_tag_in.wr_bank = w_dst_slot[0];
      w_tag_in.conj    = w_conj;
      w_tag_in.wr_addr = {w_dst_region, w_dst_slot[AW-1:1]};
    end
  end

  // NOTE: this short tag pipeline is reset (unlike a RAM) so no stale write enable survives rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BRAM_RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < BRAM_RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_tag_out     = r_tag[BRAM_RD_LAT-1];
  assign fft_bank0_wea = w_tag_out.valid & ~w_tag_out.wr_bank;
  assign fft_bank1_wea = w_tag_out.valid &  w_tag_out.wr_bank;
  assign fft_wr_addr   = w_tag_out.wr_addr;
  assign fft_wr_data   = (w_tag_out.rd_bank ? fft_bank1_rd_data : fft_bank0_rd_data)
                       ^ (DW'(w_tag_out.conj) << (FLP_WORDSIZE-1));

  assign busy = (r_state == ISSUE) || (r_state == DRAIN);
  assign done = (r_state == DONE);

endmodule
